// File: rtl/ula_arbiter.sv
// Two-requester round-robin sequencer for the shared combinational ULA.
// Each operation takes three cycles: grant/register operands, capture results, complete.
module ula_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2,
    output logic             err,
    output logic             busy,
    output logic [7:0]       ops_count,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [1:0]       ula_op,
    input  logic [WIDTH-1:0] ula_result1,
    input  logic [WIDTH-1:0] ula_result2
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    logic [1:0] state;
    logic       ptr;
    logic       sel;
    logic       any_req;
    logic       winner;

    // Contention goes to the pointer; otherwise the lone requester wins.
    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 && req1) ? ptr : req1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            sel       <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result1   <= '0;
            result2   <= '0;
            err       <= 1'b0;
            ops_count <= 8'd0;
            ula_a     <= '0;
            ula_b     <= '0;
            ula_op    <= 2'd0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        ula_a  <= winner ? a1 : a0;
                        ula_b  <= winner ? b1 : b0;
                        ula_op <= winner ? op1 : op0;
                        sel    <= winner;
                        gnt0   <= ~winner;
                        gnt1   <= winner;
                        ptr    <= ~ptr;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ULA has had the whole cycle to settle on the registered operands.
                    result1 <= ula_result1;
                    result2 <= ula_result2;
                    err     <= (ula_op == OP_DIV) && (ula_b == '0);
                    state   <= DONE;
                end
                DONE: begin
                    done0     <= ~sel;
                    done1     <= sel;
                    ops_count <= ops_count + 8'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed self-checking bench for ula_arbiter with a behavioural ULA model.
module tb_ula_arbiter;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic [1:0] op0, op1;
    logic       gnt0, gnt1, done0, done1, err, busy;
    logic [7:0] result1, result2, ops_count, ula_a, ula_b;
    logic [1:0] ula_op;
    logic [7:0] ula_result1, ula_result2;
    logic [15:0] ula_wide;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 Clock = ~Clock;

    ula_arbiter #(.WIDTH(8)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .req0        (req0),
        .req1        (req1),
        .a0          (a0),
        .b0          (b0),
        .a1          (a1),
        .b1          (b1),
        .op0         (op0),
        .op1         (op1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .result1     (result1),
        .result2     (result2),
        .err         (err),
        .busy        (busy),
        .ops_count   (ops_count),
        .ula_a       (ula_a),
        .ula_b       (ula_b),
        .ula_op      (ula_op),
        .ula_result1 (ula_result1),
        .ula_result2 (ula_result2)
    );

    // Stand-in ULA: result2 carries the high byte, borrow, or remainder.
    always_comb begin
        ula_wide    = 16'd0;
        ula_result1 = 8'd0;
        ula_result2 = 8'd0;
        case (ula_op)
            2'd0: begin
                ula_wide    = {8'd0, ula_a} + {8'd0, ula_b};
                ula_result1 = ula_wide[7:0];
                ula_result2 = ula_wide[15:8];
            end
            2'd1: begin
                ula_wide    = {8'd0, ula_a} - {8'd0, ula_b};
                ula_result1 = ula_wide[7:0];
                ula_result2 = {7'd0, ula_wide[15]};
            end
            2'd2: begin
                ula_wide    = {8'd0, ula_a} * {8'd0, ula_b};
                ula_result1 = ula_wide[7:0];
                ula_result2 = ula_wide[15:8];
            end
            default: begin
                if (ula_b != 8'd0) begin
                    ula_result1 = ula_a / ula_b;
                    ula_result2 = ula_a % ula_b;
                end else begin
                    ula_result1 = 8'hFF;
                    ula_result2 = ula_a;
                end
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0; op0 = 2'd0; op1 = 2'd0;
        repeat (2) tick();
        Reset_n = 1'b1;
    endtask

    // Raise one request, wait (bounded) for its grant, drop it, and expect done two cycles later.
    task automatic do_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
        int n;
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
        n = 0;
        do begin tick(); n++; end while (((who ? gnt1 : gnt0) !== 1'b1) && n < 10);
        check("gnt", 32'(who ? gnt1 : gnt0), 32'd1);
        if (who) req1 = 1'b0; else req0 = 1'b0;
        tick();
        check("done_early", 32'(who ? done1 : done0), 32'd0);
        check("busy_in_op", 32'(busy), 32'd1);
        tick();
        check("done", 32'(who ? done1 : done0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_done;
        int grants[$];
        int seen;

        // Reset values and a single add.
        apply_reset();
        check("rst_result1", 32'(result1), 32'd0);
        check("rst_ops", 32'(ops_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ula_a", 32'(ula_a), 32'd0);
        check("rst_gnt", 32'({gnt0, gnt1, done0, done1}), 32'd0);
        do_op(1'b0, 8'd3, 8'd4, 2'd0);
        check("add_r1", 32'(result1), 32'd7);
        check("add_r2", 32'(result2), 32'd0);
        check("add_err", 32'(err), 32'd0);
        check("add_ops", 32'(ops_count), 32'd1);
        check("add_idle", 32'(busy), 32'd0);
        check("add_ula_a", 32'(ula_a), 32'd3);
        repeat (3) tick();
        check("hold_r1", 32'(result1), 32'd7);
        check("hold_ula_b", 32'(ula_b), 32'd4);

        // Simultaneous requests: requester 0 first, then 1.
        apply_reset();
        a0 = 8'd2; b0 = 8'd3; op0 = 2'd2;
        a1 = 8'd9; b1 = 8'd5; op1 = 2'd1;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("sim_gnt", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        tick(); tick();
        check("sim_done0", 32'({done0, done1}), 32'b10);
        check("sim_r1_mul", 32'(result1), 32'd6);
        tick();
        check("sim_gnt1", 32'({gnt0, gnt1}), 32'b01);
        req1 = 1'b0;
        tick(); tick();
        check("sim_done1", 32'({done0, done1}), 32'b01);
        check("sim_r1_sub", 32'(result1), 32'd4);
        check("sim_ops", 32'(ops_count), 32'd2);

        // Fairness: both held for 12 cycles.
        apply_reset();
        a0 = 8'd1; b0 = 8'd2; op0 = 2'd0;
        a1 = 8'd7; b1 = 8'd3; op1 = 2'd1;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("exclusive", 32'((gnt0 & gnt1) | (done0 & done1) |
                                   ((gnt0 | gnt1) & (done0 | done1))), 32'd0);
            if (gnt0 || gnt1) grants.push_back(int'(gnt1));
        end
        req0 = 1'b0; req1 = 1'b0;
        check("fair_ngrants", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size(); i++) check("fair_order", 32'(grants[i]), 32'(i % 2));
        check("fair_ops", 32'(ops_count), 32'd4);
        check("fair_r1", 32'(result1), 32'd4);

        // Divide by zero, then a normal divide clears err.
        do_op(1'b1, 8'd8, 8'd0, 2'd3);
        check("dz_err", 32'(err), 32'd1);
        check("dz_r1", 32'(result1), 32'hFF);
        check("dz_r2", 32'(result2), 32'd8);
        check("dz_ops", 32'(ops_count), 32'd5);
        do_op(1'b1, 8'd8, 8'd2, 2'd3);
        check("div_err", 32'(err), 32'd0);
        check("div_r1", 32'(result1), 32'd4);
        check("div_r2", 32'(result2), 32'd0);

        // Reset during EXEC drops the operation.
        apply_reset();
        do_op(1'b0, 8'd1, 8'd1, 2'd0);
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd6; op0 = 2'd0;
        tick();
        check("mid_gnt", 32'(gnt0), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ula_a", 32'(ula_a), 32'd0);
        check("mid_ops", 32'(ops_count), 32'd0);
        check("mid_r1", 32'(result1), 32'd0);
        check("mid_gnt_clr", 32'(gnt0), 32'd0);
        req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mid_no_done", 32'({done0, done1}), 32'd0);
        end
        Reset_n = 1'b1;
        do_op(1'b0, 8'd5, 8'd6, 2'd0);
        check("mid_after_r1", 32'(result1), 32'd11);
        check("mid_after_ops", 32'(ops_count), 32'd1);

        // 256 operations wrap the counter.
        apply_reset();
        req0 = 1'b1; a0 = 8'd2; b0 = 8'd2; op0 = 2'd2;
        n_done = 0;
        n = 0;
        while (n_done < 256 && n < 1000) begin
            tick();
            n++;
            if (done0) n_done++;
        end
        req0 = 1'b0;
        check("wrap_dones", 32'(n_done), 32'd256);
        check("wrap_ops", 32'(ops_count), 32'd0);
        check("wrap_r1", 32'(result1), 32'd4);

        // A req0 pulse while serving req1 is withdrawn before IDLE sees it.
        req1 = 1'b1; a1 = 8'd10; b1 = 8'd3; op1 = 2'd3;
        n = 0;
        do begin tick(); n++; end while (gnt1 !== 1'b1 && n < 10);
        check("wd_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        req0 = 1'b1;
        tick();
        check("wd_gnt0_a", 32'(gnt0), 32'd0);
        req0 = 1'b0;
        tick();
        check("wd_done1", 32'(done1), 32'd1);
        check("wd_r1", 32'(result1), 32'd3);
        check("wd_r2", 32'(result2), 32'd1);
        check("wd_ops", 32'(ops_count), 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen += int'(gnt0) + int'(done0);
        end
        check("wd_no_gnt0", 32'(seen), 32'd0);
        check("wd_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
